// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter timer: FSM state encoding and default width.
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down-counter with terminal-count pulse and DONE/ack handshake.
// Latency: count/busy/done/tc_pulse are all registered, one edge after the causing inputs.
// Backpressure: none; enable low freezes the count, DONE is held until ack or a new load.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc_pulse   <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (load) begin
            // A load pre-empts everything, including a coincident terminal tick.
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_RUN: begin
                    if (enable) begin
                        if (count == WIDTH'(1)) begin
                            tc_nxt = 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                count_nxt = reload_reg;
                            end else begin
                                count_nxt = '0;
                                state_nxt = ST_DONE;
                            end
                        end else if (count > WIDTH'(1)) begin
                            count_nxt = count - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench: one-shot and auto-reload instances on shared stimulus, checked every cycle against a behavioural model.
module tb_down_counter_timer;

    localparam int MS_IDLE = 0;
    localparam int MS_RUN  = 1;
    localparam int MS_DONE = 2;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       enable = 1'b0;
    logic       ack = 1'b0;

    logic [3:0] count_os, count_ar;
    logic       busy_os, busy_ar, done_os, done_ar, tc_os, tc_ar;

    int vectors = 0;
    int miscompares = 0;

    // Model index 0 = one-shot, 1 = auto-reload.
    int m_count [2];
    int m_reload[2];
    int m_state [2];
    int m_tc    [2];

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_os (
        .clock(clock), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .ack(ack), .count(count_os), .busy(busy_os),
        .done(done_os), .tc_pulse(tc_os)
    );

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_ar (
        .clock(clock), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .ack(ack), .count(count_ar), .busy(busy_ar),
        .done(done_ar), .tc_pulse(tc_ar)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int m = 0; m < 2; m++) begin
                m_count[m] = 0; m_reload[m] = 0; m_state[m] = MS_IDLE; m_tc[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_tc[m] = 0;
                if (load) begin
                    m_count[m]  = int'(load_value);
                    m_reload[m] = int'(load_value);
                    m_state[m]  = (load_value != 0) ? MS_RUN : MS_IDLE;
                end else if (m_state[m] == MS_RUN && enable) begin
                    if (m_count[m] == 1) begin
                        m_tc[m] = 1;
                        if (m == 1) m_count[m] = m_reload[m];
                        else begin m_count[m] = 0; m_state[m] = MS_DONE; end
                    end else begin
                        m_count[m] = m_count[m] - 1;
                    end
                end else if (m_state[m] == MS_DONE && ack) begin
                    m_state[m] = MS_IDLE;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!clear) begin
            chk("os.count", 32'(count_os), 32'(m_count[0]));
            chk("os.busy",  32'(busy_os),  32'(m_state[0] == MS_RUN));
            chk("os.done",  32'(done_os),  32'(m_state[0] == MS_DONE));
            chk("os.tc",    32'(tc_os),    32'(m_tc[0]));
            chk("ar.count", 32'(count_ar), 32'(m_count[1]));
            chk("ar.busy",  32'(busy_ar),  32'(m_state[1] == MS_RUN));
            chk("ar.done",  32'(done_ar),  32'(m_state[1] == MS_DONE));
            chk("ar.tc",    32'(tc_ar),    32'(m_tc[1]));
        end
    end

    task automatic tick(input logic l, input int lv, input logic en, input logic a);
        load = l; load_value = 4'(lv); enable = en; ack = a;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_os(input string tag, input int c, input int t);
        chk({tag, ".os_count"}, 32'(count_os), 32'(c));
        chk({tag, ".os_tc"}, 32'(tc_os), 32'(t));
        chk({tag, ".model_os_count"}, 32'(m_count[0]), 32'(c));
    endtask

    task automatic expect_ar(input string tag, input int c, input int t);
        chk({tag, ".ar_count"}, 32'(count_ar), 32'(c));
        chk({tag, ".ar_tc"}, 32'(tc_ar), 32'(t));
        chk({tag, ".model_ar_count"}, 32'(m_count[1]), 32'(c));
    endtask

    int gate_en  [6] = '{1, 0, 0, 1, 1, 1};
    int gate_cnt [6] = '{3, 3, 3, 2, 1, 0};
    int ar_cnt   [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int pulses;

    initial begin
        #1 clear = 1'b1;
        #2;
        chk("reset.os_count", 32'(count_os), 32'd0);
        chk("reset.os_flags", 32'({busy_os, done_os, tc_os}), 32'd0);
        chk("reset.ar_count", 32'(count_ar), 32'd0);
        chk("reset.ar_flags", 32'({busy_ar, done_ar, tc_ar}), 32'd0);
        @(posedge clock); #1 clear = 1'b0;

        // One-shot from 5 with enable held
        tick(1, 5, 1, 0);
        expect_os("oneshot.load", 5, 0);
        for (int i = 4; i >= 0; i--) begin
            tick(0, 0, 1, 0);
            expect_os($sformatf("oneshot.c%0d", i), i, (i == 0) ? 1 : 0);
        end
        chk("oneshot.done", 32'(done_os), 32'd1);
        tick(0, 0, 1, 0);
        expect_os("oneshot.hold", 0, 0);
        chk("oneshot.done_held", 32'(done_os), 32'd1);
        tick(0, 0, 1, 1);
        chk("oneshot.ack_done", 32'(done_os), 32'd0);
        chk("oneshot.ack_busy", 32'(busy_os), 32'd0);

        // Enable gating from 4
        tick(1, 4, 1, 0);
        expect_os("gate.load", 4, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, logic'(gate_en[i]), 0);
            expect_os($sformatf("gate.s%0d", i), gate_cnt[i], (i == 5) ? 1 : 0);
        end
        tick(0, 0, 0, 1);

        // Auto-reload from 3 for 9 enabled cycles
        tick(1, 3, 1, 0);
        expect_ar("reload.load", 3, 0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick(0, 0, 1, 0);
            expect_ar($sformatf("reload.s%0d", i), ar_cnt[i], (i % 3 == 2) ? 1 : 0);
            chk("reload.busy", 32'(busy_ar), 32'd1);
            chk("reload.done", 32'(done_ar), 32'd0);
            pulses += int'(tc_ar);
        end
        chk("reload.pulses", 32'(pulses), 32'd3);

        // Load coinciding with terminal tick
        tick(1, 2, 1, 0);
        tick(0, 0, 1, 0);
        expect_os("collide.pre", 1, 0);
        tick(1, 7, 1, 0);
        expect_os("collide.os", 7, 0);
        expect_ar("collide.ar", 7, 0);
        chk("collide.os_busy", 32'(busy_os), 32'd1);

        // Load of zero stays idle
        tick(1, 0, 1, 0);
        expect_os("zero.load", 0, 0);
        chk("zero.busy", 32'(busy_os), 32'd0);
        tick(0, 0, 1, 0);
        expect_os("zero.hold", 0, 0);
        chk("zero.done", 32'(done_os), 32'd0);

        // Full-scale load with ack asserted during RUN
        tick(1, 15, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            tick(0, 0, 1, 1);
            expect_os($sformatf("full.e%0d", i), 15 - i, (i == 15) ? 1 : 0);
            if (i < 15) chk("full.busy_with_ack", 32'(busy_os), 32'd1);
        end
        tick(0, 0, 0, 1);

        // Asynchronous clear mid-run at count 3
        tick(1, 5, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        expect_os("clear.pre", 3, 0);
        #2 clear = 1'b1;
        #1;
        chk("clear.os_count", 32'(count_os), 32'd0);
        chk("clear.os_flags", 32'({busy_os, done_os, tc_os}), 32'd0);
        chk("clear.ar_count", 32'(count_ar), 32'd0);
        chk("clear.ar_flags", 32'({busy_ar, done_ar, tc_ar}), 32'd0);
        @(posedge clock); #1 clear = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(logic'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0));
        end

        @(posedge clock); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable, enable-gated down-counter with a terminal-count handshake. It is the complementary block to the team's free-running 4-bit up-counter: it counts down from a programmed value to zero and signals completion. It is used as a programmable delay/timeout source in the same designs. It supports one-shot and auto-reload operation.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..16)
AUTO_RELOAD, 0, 0 = one-shot (stop in DONE at zero); 1 = reload from stored value at terminal count and keep running

Ports:
clock  input  1  single system clock, rising-edge
clear  input  1  asynchronous, active-high reset
load  input  1  capture load_value into count and reload register; start counting
load_value  input  WIDTH  value to count down from
enable  input  1  count-enable; count holds while low
ack  input  1  acknowledges DONE; returns the block to IDLE
count  output  WIDTH  current counter value (registered)
busy  output  1  high in RUN state
done  output  1  high in DONE state (level, until ack or load)
tc_pulse  output  1  one-cycle pulse on every terminal count (registered)

Behaviour:
- Reset (clear=1, asynchronous): count=0, reload_reg=0, state=IDLE, busy=0, done=0, tc_pulse=0. The block leaves reset on the first rising clock edge with clear=0.
- States: IDLE, RUN, DONE. busy=(state==RUN). done=(state==DONE). Both are decoded from registered state, so there is no combinational path from inputs.
- load=1 at edge k:
  - count=load_value and reload_reg=load_value, visible after edge k.
  - If load_value!=0: state=RUN.
  - If load_value==0: state=IDLE with no tc_pulse.
  - load is accepted in every state and has the highest priority after clear.
- RUN, enable=1, count>1: count decrements by 1 per edge.
- RUN, enable=0: count, state and outputs hold. tc_pulse=0.
- RUN, enable=1, count==1 (terminal tick):
  - AUTO_RELOAD=0: count becomes 0, state becomes DONE, tc_pulse=1 for exactly one cycle.
  - AUTO_RELOAD=1: count becomes reload_reg, state stays RUN, tc_pulse=1 for one cycle. The value 0 never appears on count.
- Latency: after loading N with enable held high, tc_pulse is high in the cycle following the N-th enabled edge after the load edge. In auto-reload mode the period is exactly N enabled cycles.
- DONE: count stays 0 and enable is ignored.
  - ack=1 moves the block to IDLE on the next edge.
  - load moves it to RUN (or IDLE if loading 0).
- IDLE: count holds its last value. enable and ack are ignored.
- Simultaneous events:
  - load together with the terminal tick: load wins, no tc_pulse, count=load_value.
  - load together with ack: load wins.
  - ack outside DONE: ignored.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow cannot occur, because decrement happens only when count>1. A load of all-ones (e.g. 15 for WIDTH=4) is legal.
- tc_pulse is deasserted on every edge that is not a terminal tick.
- clear asserted mid-RUN forces reset values immediately, without waiting for a clock edge. No pulse is generated.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - the default WIDTH constant.
- No sub-module. The block is one FSM with a datapath register pair (count, reload_reg) and a registered tc_pulse.

Test Plan:
- Reset: assert clear mid-cycle during RUN at count=3 -> count=0, busy=0, done=0, tc_pulse=0 immediately, before the next clock edge.
- One-shot: AUTO_RELOAD=0, load 5, enable held high -> count goes 5,4,3,2,1,0; tc_pulse high for one cycle with count=0; done=1 held; ack -> done=0 next edge, state IDLE.
- Enable gating: load 4, enable toggles 1,0,0,1,1,1 -> count goes 4,3,3,3,2,1,0; tc_pulse fires only on the final transition.
- Auto-reload: AUTO_RELOAD=1, load 3, enable high for 9 cycles -> count goes 3,2,1,3,2,1,3,2,1,3; tc_pulse at each 1->3 transition (3 pulses); busy stays 1, done stays 0.
- Collision: load 7 asserted on the same edge as a terminal tick from count=1 -> count=7, tc_pulse=0, state RUN.
- Boundaries: load 0 -> IDLE, no pulse. Load 15 (WIDTH=4) -> full count to 0 with tc_pulse after exactly 15 enabled edges. ack in RUN is ignored.
